// File: rtl/entropy_seq_ctrl_pkg.sv
// rtl/entropy_seq_ctrl_pkg.sv - shared state encoding and sequencing constants
// Purpose: controller state enum, sample/fail thresholds and counter widths
//          shared by entropy_seq_ctrl and its bench.
package entropy_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_RUN    = 3'd2,
    ST_RECAL  = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam int WARMUP_SAMPLES  = 1024;
  localparam int RECAL_SAMPLES   = 256;
  localparam int MAX_INTER_FAILS = 4;

  localparam int SAMP_CNT_W = $clog2(WARMUP_SAMPLES + 1);
  localparam int FAIL_CNT_W = $clog2(MAX_INTER_FAILS + 1);

  // States in which the ADC strobe divider runs.
  function automatic logic is_sampling(input state_t s);
    return (s == ST_WARMUP) || (s == ST_RUN) || (s == ST_RECAL);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter
// Purpose: picks one of two requesters; the pointer moves past the winner.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (pointer -> requester 0)
//   req[1:0]  - request levels
//   en        - a grant is being taken this cycle; advances the pointer
//   gnt_any   - at least one request present
//   gnt_idx   - index of the winning requester (valid when gnt_any)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_any,
  output logic       gnt_idx
);

  // ptr names the requester that wins the next contention.
  logic ptr;

  always_comb begin
    gnt_any = |req;
    if (req == 2'b11) begin
      gnt_idx = ptr;
    end else begin
      gnt_idx = req[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (en && gnt_any) begin
      ptr <= ~gnt_idx;
    end
  end

endmodule

// File: rtl/entropy_seq_ctrl.sv
// rtl/entropy_seq_ctrl.sv - entropy source sequencer with health-test gating and word server
// Purpose: runs warm-up/run/recalibrate sequencing around an online health
//          tester and serves FIFO words to two requesters.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   cfg_div[7:0]             - ADC strobe divider, captured on start
//   start                    - begin warm-up from IDLE
//   oht_empty                - health-test FIFO empty
//   oht_inter_fail           - intermittent failure pulse
//   oht_perm_fail            - permanent failure level
//   oht_data[SAMPLE_SIZE]    - FIFO head word, valid the cycle after oht_deque
//   adc_en                   - sample strobe
//   oht_deque                - one-cycle FIFO pop
//   req[1:0]                 - per-requester word request
//   rsp_valid[1:0]           - per-requester response strobe
//   rsp_data[SAMPLE_SIZE]    - response word
//   state_o[2:0]             - current state encoding
//   fault                    - high while in FAULT
module entropy_seq_ctrl
  import entropy_seq_ctrl_pkg::*;
#(
  parameter int SAMPLE_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             cfg_div,
  input  logic                   start,
  input  logic                   oht_empty,
  input  logic                   oht_inter_fail,
  input  logic                   oht_perm_fail,
  input  logic [SAMPLE_SIZE-1:0] oht_data,
  output logic                   adc_en,
  output logic                   oht_deque,
  input  logic [1:0]             req,
  output logic [1:0]             rsp_valid,
  output logic [SAMPLE_SIZE-1:0] rsp_data,
  output logic [2:0]             state_o,
  output logic                   fault
);

  state_t                state, state_n;
  logic [7:0]            div_q, div_cnt;
  logic [SAMP_CNT_W-1:0] samp_cnt;
  logic [FAIL_CNT_W-1:0] fail_cnt;
  logic                  sampling, counting, fail_evt, fail_last;
  logic                  warm_done, recal_done;
  logic                  deq_q, cap_q, idx_q;
  logic                  grant_ok, arb_any, arb_idx;

  assign sampling   = is_sampling(state);
  assign counting   = (state == ST_WARMUP) || (state == ST_RECAL);
  assign adc_en     = sampling && (div_cnt == 8'd0);
  assign fail_evt   = sampling && oht_inter_fail;
  // This failure is the one that brings the counter to its limit.
  assign fail_last  = fail_cnt >= FAIL_CNT_W'(MAX_INTER_FAILS - 1);
  assign warm_done  = adc_en && (samp_cnt == SAMP_CNT_W'(WARMUP_SAMPLES - 1));
  assign recal_done = adc_en && (samp_cnt == SAMP_CNT_W'(RECAL_SAMPLES - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:   if (start) state_n = ST_WARMUP;
      ST_WARMUP: begin
        if (fail_evt) begin
          if (fail_last) state_n = ST_FAULT;
        end else if (warm_done) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN:    if (fail_evt) state_n = fail_last ? ST_FAULT : ST_RECAL;
      ST_RECAL:  begin
        if (fail_evt) begin
          if (fail_last) state_n = ST_FAULT;
        end else if (recal_done) begin
          state_n = ST_RUN;
        end
      end
      ST_FAULT:  state_n = ST_FAULT;
      default:   state_n = ST_IDLE;
    endcase
    // Permanent failure overrides every other transition.
    if (oht_perm_fail && (state != ST_IDLE)) state_n = ST_FAULT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Divider: adc_en fires when div_cnt is zero, so cfg_div=0 keeps it high.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= 8'd0;
      div_cnt <= 8'd0;
    end else if (state == ST_IDLE) begin
      div_cnt <= 8'd0;
      if (start) div_q <= cfg_div;
    end else if (!sampling || (div_cnt >= div_q)) begin
      div_cnt <= 8'd0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // Clean-sample counter for warm-up and recalibration; any failure or
  // state change restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt <= '0;
    end else if (counting && !fail_evt && (state_n == state)) begin
      if (adc_en) samp_cnt <= samp_cnt + SAMP_CNT_W'(1);
    end else begin
      samp_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_cnt <= '0;
    end else if ((state == ST_WARMUP) && (state_n == ST_RUN)) begin
      fail_cnt <= '0;
    end else if (fail_evt && (fail_cnt < FAIL_CNT_W'(MAX_INTER_FAILS))) begin
      fail_cnt <= fail_cnt + FAIL_CNT_W'(1);
    end
  end

  // Grants only while staying in RUN, so no pop lands in RECAL or FAULT.
  // deq_q/cap_q cover the pop and capture cycles; the response cycle may
  // overlap the next grant decision, giving a 3-cycle pop spacing.
  assign grant_ok = (state == ST_RUN) && (state_n == ST_RUN) && !oht_empty
                    && !deq_q && !cap_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .en      (grant_ok),
    .gnt_any (arb_any),
    .gnt_idx (arb_idx)
  );

  // In-flight transactions finish regardless of state; only rst drops them.
  always_ff @(posedge clk) begin
    if (rst) begin
      deq_q     <= 1'b0;
      cap_q     <= 1'b0;
      idx_q     <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
    end else begin
      deq_q     <= grant_ok && arb_any;
      cap_q     <= deq_q;
      if (grant_ok && arb_any) idx_q <= arb_idx;
      rsp_valid <= {cap_q & idx_q, cap_q & ~idx_q};
      if (cap_q) rsp_data <= oht_data;
    end
  end

  assign oht_deque = deq_q;
  assign state_o   = state;
  assign fault     = (state == ST_FAULT);

endmodule

// File: tb/tb_entropy_seq_ctrl.sv
// tb/tb_entropy_seq_ctrl.sv - self-checking bench for entropy_seq_ctrl
module tb_entropy_seq_ctrl;
  import entropy_seq_ctrl_pkg::*;

  localparam int SW = 16;

  logic          clk, rst, start, oht_empty, oht_inter_fail, oht_perm_fail;
  logic [7:0]    cfg_div;
  logic [SW-1:0] oht_data, rsp_data;
  logic          adc_en, oht_deque, fault;
  logic [1:0]    req, rsp_valid;
  logic [2:0]    state_o;

  entropy_seq_ctrl #(.SAMPLE_SIZE(SW)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_div        (cfg_div),
    .start          (start),
    .oht_empty      (oht_empty),
    .oht_inter_fail (oht_inter_fail),
    .oht_perm_fail  (oht_perm_fail),
    .oht_data       (oht_data),
    .adc_en         (adc_en),
    .oht_deque      (oht_deque),
    .req            (req),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .state_o        (state_o),
    .fault          (fault)
  );

  typedef struct { logic [1:0] vld; logic [SW-1:0] data; } exp_t;
  typedef struct { logic [1:0] req; logic [1:0] vld; } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t tbl[8];
  int   errors = 0, checks = 0, cyc = 0, last_deq = -100, pop_k = 0, exp_k = 0;
  int   viol, n, nd;
  int   dc[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [SW-1:0] word(input int k);
    return SW'(32'hA5C3 ^ (k * 32'h1357));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req_v, cyc);
    end
  endtask

  task automatic push(input logic [1:0] vld);
    exp_q.push_back('{vld, word(exp_k)});
    exp_k++;
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, input string nm);
    int k = 0;
    while (state_o !== s && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(nm, state_o, s);
  endtask

  task automatic wait_deq(input int bound, input string nm);
    int k = 0;
    while (oht_deque !== 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(nm, oht_deque, 1);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_state"}, state_o, ST_IDLE);
    chk({tag, "_adc_en"}, adc_en, 0);
    chk({tag, "_deque"}, oht_deque, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_fault"}, fault, 0);
    rst = 1'b0;
  endtask

  task automatic start_and_run(input logic [7:0] div, input string nm);
    cfg_div = div;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state(ST_RUN, 3000, nm);
  endtask

  task automatic pulse_fail();
    oht_inter_fail = 1'b1;
    @(negedge clk);
    oht_inter_fail = 1'b0;
  endtask

  // FIFO model: a popped word appears on oht_data right after the pop.
  always @(negedge clk) begin
    if (oht_deque === 1'b1) begin
      oht_data = word(pop_k);
      pop_k++;
    end
  end

  // Scoreboard: every response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (oht_deque === 1'b1) last_deq = cyc;
      if (rsp_valid !== 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=%b, required none (cycle %0d)", rsp_valid, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_valid", rsp_valid, mon_e.vld);
          chk("rsp_data", rsp_data, mon_e.data);
          chk("rsp_latency", cyc - last_deq, 2);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'b11, 2'b01};
    tbl[1] = '{2'b11, 2'b10};
    tbl[2] = '{2'b10, 2'b10};
    tbl[3] = '{2'b11, 2'b01};
    tbl[4] = '{2'b01, 2'b01};
    tbl[5] = '{2'b11, 2'b10};
    tbl[6] = '{2'b01, 2'b01};
    tbl[7] = '{2'b10, 2'b10};

    rst = 1'b1; start = 1'b0; cfg_div = 8'd1; req = 2'b00;
    oht_empty = 1'b0; oht_inter_fail = 1'b0; oht_perm_fail = 1'b0; oht_data = '0;
    apply_reset("reset");

    // Warm-up with cfg_div=1: strobe every 2nd cycle, RUN after 1024 strobes.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("warm_entry_state", state_o, ST_WARMUP);
    viol = 0; nd = 0; n = 0;
    while (state_o == ST_WARMUP && n < 3000) begin
      if (adc_en !== ((n % 2) == 0)) viol++;
      if (adc_en === 1'b1) nd++;
      @(negedge clk);
      n++;
    end
    chk("warm_to_run", state_o, ST_RUN);
    chk("warm_pulses", nd, WARMUP_SAMPLES);
    chk("warm_adc_pattern_errs", viol, 0);

    // Single-transaction arbitration vectors.
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req;
      push(tbl[i].vld);
      wait_deq(6, "tbl_deq");
      req = 2'b00;
      repeat (2) @(negedge clk);
      chk("tbl_rsp", rsp_valid, tbl[i].vld);
      repeat (2) @(negedge clk);
    end
    chk("tbl_all_rsp", exp_q.size(), 0);

    // Both requesters held: alternate 0,1,0,1 with 3-cycle pop spacing.
    req = 2'b11;
    push(2'b01); push(2'b10); push(2'b01); push(2'b10);
    nd = 0;
    for (int i = 0; i < 30 && nd < 4; i++) begin
      @(negedge clk);
      if (oht_deque === 1'b1) begin
        dc[nd] = cyc;
        nd++;
        if (nd == 4) req = 2'b00;
      end
    end
    chk("held_deq_count", nd, 4);
    for (int i = 1; i < 4; i++) chk("held_spacing", dc[i] - dc[i-1], 3);
    repeat (4) @(negedge clk);
    chk("held_all_rsp", exp_q.size(), 0);

    // Empty FIFO blocks grants; pop follows the cycle after it fills.
    oht_empty = 1'b1; req = 2'b01; viol = 0;
    repeat (6) begin
      @(negedge clk);
      if (oht_deque === 1'b1) viol++;
    end
    chk("empty_no_deq", viol, 0);
    oht_empty = 1'b0;
    push(2'b01);
    @(negedge clk);
    chk("deq_after_nonempty", oht_deque, 1);
    req = 2'b00;
    repeat (4) @(negedge clk);

    // Intermittent failures: first one lands on an outstanding transaction.
    req = 2'b01;
    push(2'b01);
    wait_deq(6, "fail1_deq");
    req = 2'b00;
    pulse_fail();
    chk("fail1_recal", state_o, ST_RECAL);
    req = 2'b01;
    push(2'b01);
    viol = 0; n = 0;
    while (state_o != ST_RUN && n < 1200) begin
      if (oht_deque === 1'b1) viol++;
      @(negedge clk);
      n++;
    end
    chk("recal_no_deq", viol, 0);
    chk("fail1_resume", state_o, ST_RUN);
    wait_deq(4, "resume_deq");
    req = 2'b00;
    repeat (4) @(negedge clk);
    chk("fail1_all_rsp", exp_q.size(), 0);
    for (int i = 2; i <= 3; i++) begin
      pulse_fail();
      chk("failn_recal", state_o, ST_RECAL);
      wait_state(ST_RUN, 1200, "failn_resume");
    end
    pulse_fail();
    chk("fail4_state", state_o, ST_FAULT);
    chk("fail4_fault", fault, 1);
    chk("fail4_adc_en", adc_en, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("fault_ignores_start", state_o, ST_FAULT);
    chk("fault_adc_en_held", adc_en, 0);

    apply_reset("rst_in_fault");

    // Reset in the middle of warm-up.
    cfg_div = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid_warm_state", state_o, ST_WARMUP);
    apply_reset("rst_warm");

    // Permanent failure with a transaction outstanding.
    start_and_run(8'd0, "run_again");
    req = 2'b10;
    push(2'b10);
    wait_deq(6, "perm_deq");
    req = 2'b00;
    oht_perm_fail = 1'b1;
    @(negedge clk);
    chk("perm_state", state_o, ST_FAULT);
    chk("perm_fault", fault, 1);
    chk("perm_adc_en", adc_en, 0);
    req = 2'b11; viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (oht_deque === 1'b1) viol++;
    end
    chk("perm_no_deq", viol, 0);
    chk("perm_rsp_done", exp_q.size(), 0);
    req = 2'b00;
    oht_perm_fail = 1'b0;

    // Reset with a transaction in flight: its response is discarded.
    apply_reset("rst_perm");
    start_and_run(8'd0, "run_third");
    req = 2'b01;
    wait_deq(6, "txn_deq");
    req = 2'b00;
    apply_reset("rst_txn");
    viol = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) viol++;
    end
    chk("rst_txn_no_rsp", viol, 0);
    exp_k = pop_k;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/entropy_seq_ctrl.md
ENTROPY_SEQ_CTRL -- requirements
Module: entropy_seq_ctrl

Interface
REQ-001 clk  in  1  system clock; all logic on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 cfg_div  in  8  ADC sample-strobe divider; captured on start.
REQ-004 start  in  1  one-cycle pulse; begins the warm-up sequence from IDLE.
REQ-005 oht_empty  in  1  health-test FIFO empty.
REQ-006 oht_inter_fail  in  1  intermittent health-test failure pulse.
REQ-007 oht_perm_fail  in  1  permanent health-test failure level.
REQ-008 oht_data  in  SAMPLE_SIZE  FIFO head word; valid the cycle after oht_deque.
REQ-009 adc_en  out  1  sample strobe to the health tester.
REQ-010 oht_deque  out  1  one-cycle FIFO pop.
REQ-011 req  in  2  per-requester word request (level; held until served).
REQ-012 rsp_valid  out  2  per-requester one-cycle response strobe.
REQ-013 rsp_data  out  SAMPLE_SIZE  response word, valid with rsp_valid.
REQ-014 state_o  out  3  current controller state encoding.
REQ-015 fault  out  1  sticky fault flag.

Function
REQ-016 States SHALL be IDLE, WARMUP, RUN, RECAL, FAULT.
REQ-017 adc_en SHALL pulse high for 1 cycle every cfg_div+1 cycles in WARMUP, RUN and RECAL; cfg_div=0 gives a continuous high; adc_en SHALL be 0 in IDLE and FAULT.
REQ-018 IDLE->WARMUP on start; the divider counter SHALL clear and the warm-up count SHALL clear; start in any other state SHALL be ignored.
REQ-019 WARMUP->RUN after WARMUP_SAMPLES adc_en pulses with no oht_inter_fail; any oht_inter_fail in WARMUP SHALL restart the warm-up count and increment the fail counter.
REQ-020 RUN->RECAL on oht_inter_fail; the fail counter SHALL increment; RECAL->RUN after RECAL_SAMPLES further adc_en pulses with no new failure.
REQ-021 Fail counter reaching MAX_INTER_FAILS, or oht_perm_fail high in any state other than IDLE, SHALL move to FAULT the next cycle; perm_fail SHALL take priority over every other transition.
REQ-022 FAULT SHALL be exited only by rst; fault=1 in FAULT, 0 otherwise.
REQ-023 The fail counter SHALL clear on entry to RUN from WARMUP only, and SHALL saturate at MAX_INTER_FAILS.
REQ-024 Grants SHALL be issued only in RUN, with oht_empty=0 and no transaction outstanding.
REQ-025 Arbitration SHALL be round-robin between the 2 requesters; the pointer SHALL advance past the served requester; requester 0 SHALL win the first contention after reset.
REQ-026 Grant cycle T: oht_deque=1; T+1: capture oht_data; T+2: rsp_valid[i]=1 with rsp_data; next grant earliest T+3.
REQ-027 A transaction outstanding when RUN->RECAL or ->FAULT SHALL still complete its rsp_valid; no new grants SHALL issue until RUN resumes.
REQ-028 A req dropped before grant SHALL be ignored; the same requester SHALL NOT receive two responses for one grant.

Reset
REQ-029 On rst: state IDLE; adc_en, oht_deque, rsp_valid, fault = 0; rsp_data = 0; counters, divider, and RR pointer cleared; any in-flight transaction discarded.
REQ-030 rst SHALL take effect in any state, including mid-transaction and in FAULT.

Structure
REQ-031 The state enum, WARMUP_SAMPLES=1024, RECAL_SAMPLES=256 and MAX_INTER_FAILS=4 SHALL live in the shared package; SAMPLE_SIZE SHALL come from params.
REQ-032 The 2-way round-robin arbiter SHALL be a sub-module named rr_arb2.

Verification
REQ-033 cfg_div=1, start -> adc_en high every 2nd cycle; RUN entered after exactly 1024 pulses; state_o tracks IDLE->WARMUP->RUN.
REQ-034 In RUN, req=2'b11 held, FIFO nonempty -> responses alternate 0,1,0,1, each rsp_valid exactly 2 cycles after its oht_deque, spacing 3 cycles.
REQ-035 4 oht_inter_fail pulses, each spaced so that RUN is resumed between them -> FAULT after the 4th, fault=1, adc_en=0, start ignored.
REQ-036 oht_perm_fail asserted during an outstanding transaction -> FAULT next cycle; the pending rsp_valid still fires; no further oht_deque.
REQ-037 oht_empty=1 with req=2'b01 in RUN -> no oht_deque; oht_empty falls -> oht_deque the next cycle.
REQ-038 rst asserted mid-WARMUP and mid-transaction -> all outputs 0 the next cycle, state IDLE, no rsp_valid afterwards.
